// File: rtl/ex_ctrl_if.sv
// ex_ctrl_if: bundle of the execute-stage sequencer's handshake and status
// signals. The "master" modport is the surrounding pipeline (decode, execute
// datapath, MEM stage); the "slave" modport is ex_ctrl itself.
//
// Handshake rules:
// - ID->EX: an instruction moves into EX on a rising edge where
//   id_valid & ex_ready is high. ex_ready never depends on id_valid.
// - EX->MEM: the EX result moves on a rising edge where
//   ex_valid & mem_ready is high (ex_fire).
// - While ex_valid is high and mem_ready is low, ex_instr is held stable.
interface ex_ctrl_if;
    logic        id_valid;
    logic [15:0] id_instr;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic        branch_cond;
    logic [15:0] pc_out_br;
    logic        err;
    logic        mem_ready;
    logic        ex_fire;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush;
    logic        halted;
    logic        err_out;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  dbg_state;

    modport master (
        output id_valid, id_instr, branch_cond, pc_out_br, err, mem_ready,
        input  ex_ready, ex_valid, ex_instr, ex_fire, redirect, redirect_pc,
               flush, halted, err_out, stall_cnt, flush_cnt, dbg_state
    );

    modport slave (
        input  id_valid, id_instr, branch_cond, pc_out_br, err, mem_ready,
        output ex_ready, ex_valid, ex_instr, ex_fire, redirect, redirect_pc,
               flush, halted, err_out, stall_cnt, flush_cnt, dbg_state
    );
endinterface

// File: rtl/ex_ctrl.sv
// ex_ctrl: execute-stage pipeline sequencer for the 16-bit WISC core.
// It owns the ID/EX occupancy register and inserts load-use bubbles. It turns
// a resolved branch or jump into a one-cycle redirect/flush, and it stops the
// pipe on HALT or an ALU error.
// Optional feature: define EX_CTRL_PERF_EN to build the saturating
// stall_cnt/flush_cnt performance counters. When it is undefined, both
// outputs read zero and no counter flops exist.
module ex_ctrl #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic     clk,
    input  logic     rst,
    ex_ctrl_if.slave bus
);

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_LD   = 5'b10001;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_ex_valid;
    logic [15:0] r_ex_instr;
    logic [15:0] r_redirect_pc;
    logic        r_err_out;

    logic        w_halt_op;
    logic        w_is_ld;
    logic        w_lu;
    logic        w_fire;
    logic        w_ready;
    logic        w_kill;
    logic        w_to_halt;
    logic        w_to_redirect;

    // Decode the instruction currently held in EX.
    always_comb begin
        w_halt_op = (r_ex_instr[15:11] == OP_HALT);
        w_is_ld   = (r_ex_instr[15:11] == OP_LD);
    end

    // Load-use hazard. The register-field comparison is deliberately
    // conservative: both ID source fields are compared for every format.
    always_comb begin
        w_lu = r_ex_valid && w_is_ld &&
               ((r_ex_instr[7:5] == bus.id_instr[10:8]) ||
                (r_ex_instr[7:5] == bus.id_instr[7:5]));
    end

    // Handshake decode. An instruction in EX that will redirect, halt or
    // raise an error blocks acceptance, so no wrong-path or post-HALT
    // instruction ever enters the slot.
    always_comb begin
        w_fire  = r_ex_valid && bus.mem_ready;
        w_kill  = r_ex_valid && (bus.branch_cond || bus.err || w_halt_op);
        w_ready = (r_state == ST_RUN) &&
                  (!r_ex_valid || bus.mem_ready) &&
                  !w_lu && !w_kill;
    end

    // Next-state logic. Priority inside RUN: error, then HALT, then branch.
    always_comb begin
        w_next_state  = r_state;
        w_to_halt     = 1'b0;
        w_to_redirect = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_fire && (bus.err || w_halt_op)) begin
                    w_next_state = ST_HALTED;
                    w_to_halt    = 1'b1;
                end else if (w_fire && bus.branch_cond) begin
                    w_next_state  = ST_REDIRECT;
                    w_to_redirect = 1'b1;
                end
            end
            ST_REDIRECT: begin
                w_next_state = ST_RUN;
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ID/EX occupancy register. Accepting wins over firing, so accept and
    // fire in the same cycle simply overwrite the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_instr <= NOP_INSTR;
        end else if (bus.id_valid && w_ready) begin
            r_ex_valid <= 1'b1;
            r_ex_instr <= bus.id_instr;
        end else if (w_fire) begin
            r_ex_valid <= 1'b0;
            r_ex_instr <= NOP_INSTR;
        end
    end

    // Capture the redirect target and the error flag on the deciding fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_pc <= 16'h0000;
            r_err_out     <= 1'b0;
        end else begin
            if (w_to_redirect) begin
                r_redirect_pc <= bus.pc_out_br;
            end
            if (w_to_halt) begin
                r_err_out <= bus.err;
            end
        end
    end

`ifdef EX_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating performance counters for load-use stalls and redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if ((r_state == ST_RUN) && bus.id_valid && w_lu &&
                (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_to_redirect && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = 16'h0000;
    assign bus.flush_cnt = 16'h0000;
`endif

    assign bus.ex_ready    = w_ready;
    assign bus.ex_fire     = w_fire;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_instr    = r_ex_instr;
    assign bus.redirect    = (r_state == ST_REDIRECT);
    assign bus.flush       = (r_state == ST_REDIRECT);
    assign bus.halted      = (r_state == ST_HALTED);
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.err_out     = r_err_out;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ex_ctrl.sv
// tb_ex_ctrl: self-checking bench for ex_ctrl. A negedge monitor keeps an
// expected queue of accepted instructions and checks every EX->MEM transfer
// against it. Each scenario task checks the control outputs inline.
module tb_ex_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [15:0] exp_q[$];
    logic [15:0] exp_item;

`ifdef EX_CTRL_PERF_EN
    localparam logic [15:0] PERF_ONE = 16'd1;
`else
    localparam logic [15:0] PERF_ONE = 16'd0;
`endif

    ex_ctrl_if bus ();

    ex_ctrl #(.NOP_INSTR(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop and compare on ex_fire, push on an accept
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.ex_fire) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: ex_instr=%h fired, expected nothing", bus.ex_instr);
                end else begin
                    exp_item = exp_q.pop_front();
                    if (bus.ex_instr !== exp_item) begin
                        bad++;
                        $display("FAIL sb_ex_instr: got %h want %h", bus.ex_instr, exp_item);
                    end
                end
            end
            if (bus.id_valid && bus.ex_ready) exp_q.push_back(bus.id_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid    = 1'b0;
        bus.id_instr    = 16'h0800;
        bus.branch_cond = 1'b0;
        bus.pc_out_br   = 16'h0000;
        bus.err         = 1'b0;
        bus.mem_ready   = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Accept one instruction into the empty slot, leave it in EX
    task automatic load_ex(input logic [15:0] instr);
        bus.id_valid  = 1'b1;
        bus.id_instr  = instr;
        bus.mem_ready = 1'b1;
        tick();
        bus.id_valid  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid: got %b want 0", bus.ex_valid); end
        total++; if (bus.ex_instr !== 16'h0800) begin bad++; $display("FAIL rst_ex_instr: got %h want 0800", bus.ex_instr); end
        total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ex_ready: got %b want 1", bus.ex_ready); end
        total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect: got %b want 0", bus.redirect); end
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
        total++; if (bus.err_out !== 1'b0) begin bad++; $display("FAIL rst_err_out: got %b want 0", bus.err_out); end
        total++; if (bus.redirect_pc !== 16'h0000) begin bad++; $display("FAIL rst_redirect_pc: got %h want 0000", bus.redirect_pc); end
        total++; if (bus.stall_cnt !== 16'h0000) begin bad++; $display("FAIL rst_stall_cnt: got %h want 0000", bus.stall_cnt); end
        total++; if (bus.flush_cnt !== 16'h0000) begin bad++; $display("FAIL rst_flush_cnt: got %h want 0000", bus.flush_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bus.id_valid  = 1'b1;
        bus.id_instr  = 16'hD8A4;
        bus.mem_ready = 1'b1;
        #2;
        total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", bus.ex_ready); end
        tick();
        bus.id_valid = 1'b0;
        #2;
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL basic_ex_valid: got %b want 1", bus.ex_valid); end
        total++; if (bus.ex_instr !== 16'hD8A4) begin bad++; $display("FAIL basic_ex_instr: got %h want D8A4", bus.ex_instr); end
        total++; if (bus.ex_fire !== 1'b1) begin bad++; $display("FAIL basic_ex_fire: got %b want 1", bus.ex_fire); end
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", bus.ex_valid); end
    endtask

    // Random non-LD, non-HALT traffic with random MEM backpressure
    task automatic test_random_stream();
        logic        m_valid;
        logic        exp_ready;
        logic [4:0]  op;
        logic [15:0] rnd;
        do_reset();
        m_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            op  = 5'($urandom_range(1, 31));
            if (op == 5'b10001) op = 5'b10010;
            rnd = 16'($urandom_range(0, 2047));
            bus.id_valid  = 1'($urandom_range(0, 1));
            bus.id_instr  = {op, rnd[10:0]};
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            #2;
            exp_ready = !m_valid || bus.mem_ready;
            total++; if (bus.ex_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.ex_ready, exp_ready); end
            total++; if (bus.ex_fire !== (m_valid && bus.mem_ready)) begin bad++; $display("FAIL rnd_fire[%0d]: got %b want %b", i, bus.ex_fire, m_valid && bus.mem_ready); end
            if (bus.id_valid && exp_ready) m_valid = 1'b1;
            else if (m_valid && bus.mem_ready) m_valid = 1'b0;
            tick();
        end
        bus.id_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_queue_empty: got %0d entries want 0", exp_q.size()); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_ex(16'h8A40);
        bus.id_valid = 1'b1;
        bus.id_instr = 16'hDA04;
        #2;
        total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %b want 0", bus.ex_ready); end
        total++; if (bus.ex_fire !== 1'b1) begin bad++; $display("FAIL lu_ld_fire: got %b want 1", bus.ex_fire); end
        tick();
        total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL lu_accept_after: got %b want 1", bus.ex_ready); end
        tick();
        bus.id_valid = 1'b0;
        total++; if (bus.ex_instr !== 16'hDA04) begin bad++; $display("FAIL lu_dep_in_ex: got %h want DA04", bus.ex_instr); end
        total++; if (bus.stall_cnt !== PERF_ONE) begin bad++; $display("FAIL lu_stall_cnt: got %h want %h", bus.stall_cnt, PERF_ONE); end
        tick();
        // Independent instruction behind a load: no bubble
        load_ex(16'h8A40);
        bus.id_valid = 1'b1;
        bus.id_instr = 16'hD8A4;
        #2;
        total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL lu_no_hazard: got %b want 1", bus.ex_ready); end
        tick();
        bus.id_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        load_ex(16'h6000);
        bus.branch_cond = 1'b1;
        bus.pc_out_br   = 16'h0040;
        bus.id_valid    = 1'b1;
        bus.id_instr    = 16'hD8A4;
        #2;
        total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL br_not_accepted: got %b want 0", bus.ex_ready); end
        total++; if (bus.ex_fire !== 1'b1) begin bad++; $display("FAIL br_fire: got %b want 1", bus.ex_fire); end
        tick();
        bus.branch_cond = 1'b0;
        #2;
        total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL br_redirect: got %b want 1", bus.redirect); end
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL br_flush: got %b want 1", bus.flush); end
        total++; if (bus.redirect_pc !== 16'h0040) begin bad++; $display("FAIL br_redirect_pc: got %h want 0040", bus.redirect_pc); end
        total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL br_ready_in_redirect: got %b want 0", bus.ex_ready); end
        tick();
        #2;
        total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL br_redirect_one_cycle: got %b want 0", bus.redirect); end
        total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL br_ready_back: got %b want 1", bus.ex_ready); end
        total++; if (bus.flush_cnt !== PERF_ONE) begin bad++; $display("FAIL br_flush_cnt: got %h want %h", bus.flush_cnt, PERF_ONE); end
        tick();
        bus.id_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_branch_stall();
        do_reset();
        load_ex(16'h6000);
        bus.mem_ready   = 1'b0;
        bus.branch_cond = 1'b1;
        bus.pc_out_br   = 16'h1234;
        bus.id_valid    = 1'b1;
        bus.id_instr    = 16'hD8A4;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL brs_no_redirect[%0d]: got %b want 0", i, bus.redirect); end
            total++; if (bus.ex_instr !== 16'h6000) begin bad++; $display("FAIL brs_stable[%0d]: got %h want 6000", i, bus.ex_instr); end
            total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL brs_ready[%0d]: got %b want 0", i, bus.ex_ready); end
            tick();
        end
        bus.mem_ready = 1'b1;
        #2;
        total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL brs_rise_cycle: got %b want 0", bus.redirect); end
        tick();
        bus.branch_cond = 1'b0;
        bus.id_valid    = 1'b0;
        #2;
        total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL brs_redirect: got %b want 1", bus.redirect); end
        total++; if (bus.redirect_pc !== 16'h1234) begin bad++; $display("FAIL brs_redirect_pc: got %h want 1234", bus.redirect_pc); end
        tick();
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        load_ex(16'h0000);
        bus.id_valid = 1'b1;
        bus.id_instr = 16'hD8A4;
        #2;
        total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL halt_block: got %b want 0", bus.ex_ready); end
        tick();
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_halted: got %b want 1", bus.halted); end
        total++; if (bus.err_out !== 1'b0) begin bad++; $display("FAIL halt_err_out: got %b want 0", bus.err_out); end
        repeat (3) tick();
        total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL halt_ready_held: got %b want 0", bus.ex_ready); end
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL halt_slot_empty: got %b want 0", bus.ex_valid); end
        // Error on the firing instruction
        do_reset();
        load_ex(16'hD8A4);
        bus.err      = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_instr = 16'hD8A4;
        #2;
        total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL err_block: got %b want 0", bus.ex_ready); end
        tick();
        bus.err      = 1'b0;
        bus.id_valid = 1'b0;
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL err_halted: got %b want 1", bus.halted); end
        total++; if (bus.err_out !== 1'b1) begin bad++; $display("FAIL err_err_out: got %b want 1", bus.err_out); end
        tick();
    endtask

    task automatic test_rst_in_redirect();
        do_reset();
        load_ex(16'h6000);
        bus.branch_cond = 1'b1;
        bus.pc_out_br   = 16'h0abc;
        tick();
        bus.branch_cond = 1'b0;
        total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL rr_in_redirect: got %b want 1", bus.redirect); end
        rst = 1'b1;
        #1;
        total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL rr_redirect: got %b want 0", bus.redirect); end
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL rr_flush: got %b want 0", bus.flush); end
        total++; if (bus.redirect_pc !== 16'h0000) begin bad++; $display("FAIL rr_redirect_pc: got %h want 0000", bus.redirect_pc); end
        total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL rr_ex_ready: got %b want 1", bus.ex_ready); end
        total++; if (bus.flush_cnt !== 16'h0000) begin bad++; $display("FAIL rr_flush_cnt: got %h want 0000", bus.flush_cnt); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL rr_no_partial: got %b want 0", bus.redirect); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_random_stream();
        test_load_use();
        test_branch();
        test_branch_stall();
        test_halt();
        test_rst_in_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
